// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package if_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of {pc, inst} fetch entries; flush wins over a same-cycle push.
module if_fetch_unit_fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           data_i,
    output fetch_entry_t           data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer wrap relies on DEPTH being a power of two.
    always_comb begin : next_state
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin : storage
        mem_q <= mem_d;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: PC generation, req/gnt/rvalid memory interface,
// in-order response buffering and the registered IF/ID output stage.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] PC_o,
    output logic [XLEN-1:0] Inst_o,
    output logic            inst_valid_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            valid_q, valid_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic            fifo_push, fifo_pop;
    fetch_entry_t    fifo_wdata, fifo_rdata;

    logic            req, handshake, rsp;
    logic [XLEN-1:0] redirect_target;

    // Credit: in-flight plus buffered entries never exceed the FIFO depth.
    always_comb begin : request_logic
        redirect_target = word_align(redirect_pc_i);
        req = (state_q == ST_RUN) && !redirect_i &&
              (((CW+1)'(outstanding_q) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH));
        handshake = req && imem_gnt_i;
        rsp       = imem_rvalid_i && (outstanding_q != '0);
    end

    always_comb begin : next_state
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        valid_d       = valid_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_wdata    = '{pc: resp_pc_q, inst: imem_rdata_i};

        if (handshake && !rsp) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (rsp && !handshake) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        if (handshake) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        // Responses are only kept in RUN; in FLUSH they just retire credit.
        if (rsp && (state_q == ST_RUN) && !redirect_i && !fifo_full) begin
            fifo_push = 1'b1;
            resp_pc_d = resp_pc_q + XLEN'(4);
        end

        unique case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (redirect_i && (outstanding_d != '0)) state_d = ST_FLUSH;
            ST_FLUSH: if (!redirect_i && (outstanding_d == '0)) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase

        // Redirect overrides stall and any pending pop.
        if (redirect_i) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            inst_d     = NOP_INST;
            valid_d    = 1'b0;
        end else if (!stall_i) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                pc_d     = fifo_rdata.pc;
                inst_d   = fifo_rdata.inst;
                valid_d  = 1'b1;
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= word_align(RESET_PC);
            resp_pc_q     <= word_align(RESET_PC);
            outstanding_q <= '0;
            pc_q          <= '0;
            inst_q        <= NOP_INST;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            valid_q       <= valid_d;
        end
    end

    if_fetch_unit_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign imem_req_o   = req;
    assign imem_addr_o  = fetch_pc_q;
    assign PC_o         = pc_q;
    assign Inst_o       = inst_q;
    assign inst_valid_o = valid_q;

    // A response with nothing in flight means the memory side broke protocol.
    rvalid_without_request: assert property (
        @(posedge clk) disable iff (!rst_n) !(imem_rvalid_i && (outstanding_q == '0))
    );

endmodule
